// File: rtl/prewish_mask_loader.sv
// ============================================================================
// Module   : prewish_mask_loader
// Brief    : Debounces the load button, samples the 8-bit DIP switch and emits
//            a single-cycle load strobe with the mask for prewish_mentor.
//            Optional macro: PREWISH_LOADER_AUTOREPEAT_EN (auto-repeat while held)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module prewish_mask_loader #(
   parameter int DEBOUNCE_BITS  = 16,
   parameter int REPEAT_BITS    = 23,
   parameter int BTN_ACTIVE_LOW = 1
) (
   input  logic       CLK_I,
   input  logic       RST_I,
   input  logic       i_btn,
   input  logic [7:0] i_dip,
   output logic       STB_O,
   output logic [7:0] DAT_O,
   output logic       o_pressed
);

   localparam logic [1:0] C_IDLE     = 2'd0;
   localparam logic [1:0] C_DB_PRESS = 2'd1;
   localparam logic [1:0] C_WAIT_REL = 2'd2;
   localparam logic [1:0] C_DB_REL   = 2'd3;

   localparam logic [DEBOUNCE_BITS-1:0] C_CNT_MAX  = '1;
   localparam logic                     C_BTN_IDLE = (BTN_ACTIVE_LOW != 0);

   logic                     btn_meta_q, btn_meta_d;
   logic                     btn_sync_q, btn_sync_d;
   logic [7:0]               dip_meta_q, dip_meta_d;
   logic [7:0]               dip_sync_q, dip_sync_d;
   logic [1:0]               state_q, state_d;
   logic [DEBOUNCE_BITS-1:0] cnt_q, cnt_d;
   logic                     stb_q, stb_d;
   logic [7:0]               dat_q, dat_d;
   logic                     pressed_q, pressed_d;
   logic                     w_btn_s;
   logic                     w_first_stb;

`ifdef PREWISH_LOADER_AUTOREPEAT_EN
   localparam logic [REPEAT_BITS-1:0] C_RPT_MAX = '1;
   logic [REPEAT_BITS-1:0]   rpt_q, rpt_d;
`else
   logic [31:0]              w_unused_repeat_bits;
   assign w_unused_repeat_bits = 32'(REPEAT_BITS);
`endif

   // Two-flop synchronizers; the button is normalized to 1 = pressed after them.
   always_comb begin
      btn_meta_d = i_btn;
      btn_sync_d = btn_meta_q;
      dip_meta_d = i_dip;
      dip_sync_d = dip_meta_q;
   end

   assign w_btn_s = (BTN_ACTIVE_LOW != 0) ? ~btn_sync_q : btn_sync_q;

   always_ff @(posedge CLK_I) begin
      if (RST_I) begin
         btn_meta_q <= C_BTN_IDLE;
         btn_sync_q <= C_BTN_IDLE;
         dip_meta_q <= 8'h00;
         dip_sync_q <= 8'h00;
         state_q    <= C_IDLE;
         cnt_q      <= '0;
         stb_q      <= 1'b0;
         dat_q      <= 8'h00;
         pressed_q  <= 1'b0;
`ifdef PREWISH_LOADER_AUTOREPEAT_EN
         rpt_q      <= '0;
`endif
      end else begin
         btn_meta_q <= btn_meta_d;
         btn_sync_q <= btn_sync_d;
         dip_meta_q <= dip_meta_d;
         dip_sync_q <= dip_sync_d;
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         stb_q      <= stb_d;
         dat_q      <= dat_d;
         pressed_q  <= pressed_d;
`ifdef PREWISH_LOADER_AUTOREPEAT_EN
         rpt_q      <= rpt_d;
`endif
      end
   end

   // Next-state: the counter saturates at MAX; any opposite sample restarts debounce.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         C_IDLE: begin
            if (w_btn_s) begin
               state_d = C_DB_PRESS;
               cnt_d   = '0;
            end
         end
         C_DB_PRESS: begin
            if (!w_btn_s)                state_d = C_IDLE;
            else if (cnt_q == C_CNT_MAX) state_d = C_WAIT_REL;
            else                         cnt_d   = cnt_q + 1'b1;
         end
         C_WAIT_REL: begin
            if (!w_btn_s) begin
               state_d = C_DB_REL;
               cnt_d   = '0;
            end
         end
         C_DB_REL: begin
            if (w_btn_s)                 state_d = C_WAIT_REL;
            else if (cnt_q == C_CNT_MAX) state_d = C_IDLE;
            else                         cnt_d   = cnt_q + 1'b1;
         end
         default: begin
            state_d = C_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   assign w_first_stb = (state_q == C_DB_PRESS) && w_btn_s && (cnt_q == C_CNT_MAX);

   always_comb begin
      stb_d     = 1'b0;
      dat_d     = dat_q;
      pressed_d = (state_d == C_WAIT_REL) || (state_d == C_DB_REL);
      if (w_first_stb) begin
         stb_d = 1'b1;
         dat_d = dip_sync_q;
      end
`ifdef PREWISH_LOADER_AUTOREPEAT_EN
      // rpt only advances while held in WAIT_REL and survives DB_REL glitches.
      rpt_d = rpt_q;
      if (w_first_stb) begin
         rpt_d = '0;
      end else if ((state_q == C_WAIT_REL) && w_btn_s) begin
         if (rpt_q == C_RPT_MAX) begin
            stb_d = 1'b1;
            dat_d = dip_sync_q;
            rpt_d = '0;
         end else begin
            rpt_d = rpt_q + 1'b1;
         end
      end
`endif
   end

   assign STB_O     = stb_q;
   assign DAT_O     = dat_q;
   assign o_pressed = pressed_q;

endmodule

`default_nettype wire
